// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU with a valid/ready handshake. Single-cycle ops finish
// on the accept edge. MUL/DIVU/REMU iterate one bit per cycle for WIDTH cycles.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic             busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The producer holds in_valid and operands until that edge. The
  // consumer sees result and flags held stable while out_valid is high and
  // out_ready is low.

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLT  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [3:0]       op_r;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] acc;   // MUL: partial product; DIV: partial remainder
  logic [WIDTH-1:0] x;     // MUL: shifted multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] y;     // MUL: shifted multiplier; DIV: divisor

  logic             accept;
  logic             is_multi;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] calc_res;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_multi = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign shamt    = b[SH_W-1:0];
  assign sum      = a + b;
  assign diff     = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration step. A zero divisor never borrows, so DIVU naturally
  // yields all ones and REMU yields the dividend.
  always_comb begin
    mul_acc = acc + (y[0] ? x : '0);
    r_shift = {acc, x[WIDTH-1]};
    r_diff  = r_shift - {1'b0, y};
    div_ok  = ~r_diff[WIDTH];
    div_rem = div_ok ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    div_quo = {x[WIDTH-2:0], div_ok};
    case (op_r)
      OP_MUL:  calc_res = mul_acc;
      OP_DIVU: calc_res = div_quo;
      default: calc_res = div_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= '0;
      counter   <= '0;
      acc       <= '0;
      x         <= '0;
      y         <= '0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      op_r    <= op;
      counter <= '0;
      if (is_multi) begin
        state     <= CALC;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        acc       <= '0;
        x         <= a;
        y         <= b;
      end else begin
        state     <= DONE;
        busy      <= 1'b0;
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
        illegal   <= alu_ill;
      end
    end else begin
      case (state)
        CALC: begin
          counter <= counter + 1'b1;
          if (op_r == OP_MUL) begin
            acc <= mul_acc;
            x   <= x << 1;
            y   <= y >> 1;
          end else begin
            acc <= div_rem;
            x   <= div_quo;
          end
          if (counter == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= calc_res;
            zero      <= (calc_res == '0);
            ovf       <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed plus random checks of alu_multicycle at WIDTH=32. A scoreboard
// queue holds expected {result, zero, ovf, illegal} per accepted op.
module tb_alu_multicycle;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;
  logic         busy;

  logic [W+2:0] exp_q[$];
  int           pop_cyc[$];
  int           cyc;
  int           n_checks;
  int           fails;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .illegal(illegal), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         v;
    logic         il;
    logic [63:0]  p;
    longint       sx;
    longint       sy;
    longint       s;
    r = '0; v = 1'b0; il = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    p = {32'b0, x} * {32'b0, y};
    case (o)
      4'd0:  begin r = x + y; s = sx + sy; v = (s > SMAX) || (s < SMIN); end
      4'd1:  r = (sx < sy) ? 1 : 0;
      4'd2:  begin r = x - y; s = sx - sy; v = (s > SMAX) || (s < SMIN); end
      4'd3:  r = (x < y) ? 1 : 0;
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = ~(x | y);
      4'd7:  r = x ^ y;
      4'd8:  r = x << y[4:0];
      4'd9:  r = x >> y[4:0];
      4'd10: r = W'(sx >>> y[4:0]);
      4'd12: r = p[31:0];
      4'd13: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd14: r = (y == 0) ? x : x % y;
      default: il = 1'b1;
    endcase
    return {r, (r == 0), v, il};
  endfunction

  // driver tasks
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(model(o, x, y));
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) begin
      n_checks++;
      fails++;
      $error("FAIL accept_timeout: in_ready %0b expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    n_checks++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // scoreboard: one comparison set per completed output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_output: result %0h expected none", result);
      end
      if (exp_q.size() != 0) begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        chk("result", 64'(result), 64'(e[W+2:3]));
        chk("zero", 64'(zero), 64'(e[2]));
        chk("ovf", 64'(ovf), 64'(e[1]));
        chk("illegal", 64'(illegal), 64'(e[0]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    int lat;
    int busy_cnt;
    logic [W-1:0] held;
    n_checks = 0; fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_zero", 64'(zero), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", 64'(in_ready), 1);

    // single-cycle ops, 1-cycle latency
    send(4'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_latency_valid", 64'(out_valid), 1);
    send(4'd2, 32'd5, 32'd5);
    send(4'd1, 32'hFFFF_FFFF, 32'h1);
    send(4'd3, 32'hFFFF_FFFF, 32'h1);
    send(4'd10, 32'h8000_0000, 32'h24);
    send(4'd9, 32'h8000_0000, 32'h24);
    send(4'd2, 32'h8000_0000, 32'h1);
    send(4'd8, 32'h0000_0013, 32'hFFFF_FFE3);
    send(4'd6, 32'h0F0F_0000, 32'h0000_F0F0);
    send(4'd15, 32'h1234, 32'h5678);
    send(4'd11, 32'h1, 32'h1);
    send(4'd7, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    drain();

    // multi-cycle latency, busy and in_ready during CALC
    send(4'd12, 32'd7, 32'd6);
    lat = 1; busy_cnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      chk("in_ready_calc", 64'(in_ready), 0);
      @(posedge clk);
      #1 lat++;
    end
    chk("mul_latency", 64'(lat), 33);
    chk("mul_busy_cycles", 64'(busy_cnt), 32);
    drain();
    send(4'd13, 32'd100, 32'd7);
    send(4'd14, 32'd100, 32'd7);
    send(4'd13, 32'd9, 32'd0);
    send(4'd14, 32'd9, 32'd0);
    send(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(4'd13, 32'hFFFF_FFFF, 32'h1);
    drain();

    // back-pressure holds DONE
    out_ready = 1'b0;
    send(4'd0, 32'd3, 32'd4);
    held = result;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_result_stable", 64'(result), 64'(held));
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_in_ready", 64'(in_ready), 0);
    end
    out_ready = 1'b1;
    drain();

    // four back-to-back ADDs: results on consecutive cycles
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) send(4'd0, 32'(i * 11), 32'(100 + i));
    drain();
    chk("stream_count", 64'(pop_cyc.size()), 4);
    for (int i = 1; i < 4 && i < pop_cyc.size(); i++)
      chk("stream_spacing", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));

    // random mix
    for (int i = 0; i < 16; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      send(o, $urandom(), (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom());
    end
    drain();

    // reset mid-CALC aborts the op
    send(4'd0, 32'h1, 32'h2);
    drain();
    send(4'd12, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_result", 64'(result), 0);
    chk("arst_flags", 64'({zero, ovf, illegal}), 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", 64'(in_ready), 1);
    chk("arst_no_valid", 64'(out_valid), 0);
    repeat (40) @(posedge clk);
    #1 chk("arst_no_result", 64'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the combinational datapath ALU; sits in the EX stage of the pipelined MIPS datapath.
- Single-cycle ops complete with 1-cycle registered latency.
- Adds iterative multiply/divide/remainder, signed/unsigned compare and status flags.
- Uses a valid/ready handshake so the hazard unit can stall EX while a multi-cycle op runs.

Parameters:
- WIDTH, 32, operand/result width; must be ≥4 and a power of two.
- SH_W, $clog2(WIDTH), shift-amount bits taken from b.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an op this cycle.
- op  in  4  operation code.
- a  in  WIDTH  operand 1 (rs).
- b  in  WIDTH  operand 2 (rt/imm/shamt).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow (ADD/SUB only, else 0).
- illegal  out  1  opcode not in table below.
- busy  out  1  multi-cycle op in progress.

Behaviour:
- Opcodes:
  - 0000 ADD; 0001 SLT (signed, result 1/0); 0010 SUB (a−b); 0011 SLTU.
  - 0100 AND; 0101 OR; 0110 NOR; 0111 XOR.
  - 1000 SLL; 1001 SRL (logical, zero fill); 1010 SRA (arithmetic, sign fill).
  - 1100 MUL (low WIDTH bits of a*b, unsigned); 1101 DIVU (quotient); 1110 REMU (remainder).
  - 1011, 1111: illegal.
- Shifts: amount = b[SH_W-1:0]; upper bits of b ignored.
- ovf:
  - ADD: a, b same sign and result sign differs.
  - SUB: a, b signs differ and result sign differs from a.
- Divide by zero (b==0): DIVU → all ones; REMU → a. No extra flag; same latency as a normal divide.
- Illegal op: result 0, illegal=1, zero=1, single-cycle path.
- FSM states IDLE, CALC, DONE:
  - Accept = in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept with single-cycle op → DONE next edge, result/flags registered.
  - Accept with MUL/DIVU/REMU → CALC; load operands, counter=0, busy=1.
  - CALC: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle. After WIDTH steps (counter==WIDTH-1 on the edge) → DONE.
  - DONE: out_valid=1; result, zero, ovf, illegal held stable until out_ready.
  - DONE & out_ready & no accept → IDLE.
  - DONE & out_ready & accept → next op loaded same edge, so back-to-back single-cycle ops sustain 1 op/cycle.
- Latency, accept edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- busy = (state==CALC).
- Reset (async, rst_n=0):
  - state IDLE; result=0, zero=0, ovf=0, illegal=0, out_valid=0, busy=0, counter=0.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-CALC or mid-DONE aborts the op silently; no result emitted.
- All outputs are registered except in_ready, which is combinational from state and out_ready.
- Arithmetic is modulo 2^WIDTH; no internal width growth is visible at the ports.

Test Plan:
- Reset: drive rst_n=0 mid-CALC of a MUL → all outputs 0 immediately (async). After release, in_ready=1, out_valid=0.
- ADD overflow: WIDTH=32, ADD a=0x7FFFFFFF, b=1 → after 1 cycle result=0x80000000, ovf=1, zero=0. SUB a=5, b=5 → result 0, zero=1, ovf=0.
- Compare/shift: SLT a=0xFFFFFFFF, b=1 → 1; SLTU same operands → 0. SRA a=0x80000000, b=0x24 (amount 4) → 0xF8000000. SRL same → 0x08000000.
- Multi-cycle: MUL 7×6 → out_valid exactly 33 cycles after accept, result=42, busy high 32 cycles, in_ready=0 throughout. DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- Back-pressure and throughput: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Then stream 4 ADDs with out_ready=1 → 4 results on 4 consecutive cycles, in order.
- Illegal: op=1111 → result 0, illegal=1, zero=1 after 1 cycle. A following legal op clears illegal.
